// File: rtl/prewish5k_pattern_blinker.sv
// Strobe/data receiver: latches an 8-bit pattern on a STB_I rising edge and plays it MSB-first on o_led.
// Build option PREWISH5K_ONESHOT_EN: play the pattern once and return to IDLE instead of looping.
module prewish5k_pattern_blinker #(
    parameter int unsigned PRESCALE_BITS = 3
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       STB_I,
    input  logic [7:0] DAT_I,
    output logic       ACK_O,
    output logic       o_busy,
    output logic       o_led
);

    typedef enum logic {
        IDLE,
        PLAY
    } state_t;

    state_t                   state_q, state_d;
    logic                     stb_prev_q, stb_prev_d;
    logic [7:0]               pattern_q, pattern_d;
    logic [2:0]               bit_idx_q, bit_idx_d;
    logic [PRESCALE_BITS-1:0] presc_q, presc_d;
    logic                     ack_q, ack_d;
    logic                     busy_q, busy_d;
    logic                     led_q, led_d;

    logic       accept;
    logic [2:0] next_idx;

    assign accept   = STB_I & ~stb_prev_q;
    assign next_idx = bit_idx_q - 3'd1;

    always_comb begin
        state_d    = state_q;
        stb_prev_d = STB_I;
        pattern_d  = pattern_q;
        bit_idx_d  = bit_idx_q;
        presc_d    = presc_q;
        ack_d      = 1'b0;
        busy_d     = busy_q;
        led_d      = led_q;

        // A new word always wins, including over a prescaler wrap on the same edge.
        if (accept) begin
            pattern_d = DAT_I;
            bit_idx_d = 3'd7;
            presc_d   = '0;
            state_d   = PLAY;
            ack_d     = 1'b1;
            busy_d    = 1'b1;
            led_d     = DAT_I[7];
        end else begin
            case (state_q)
                IDLE: begin
                    led_d  = 1'b0;
                    busy_d = 1'b0;
                end
                PLAY: begin
                    busy_d  = 1'b1;
                    presc_d = presc_q + PRESCALE_BITS'(1);
                    if (presc_q == '1) begin
                        if (bit_idx_q == 3'd0) begin
                            bit_idx_d = 3'd7;
`ifdef PREWISH5K_ONESHOT_EN
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            led_d   = 1'b0;
`else
                            led_d   = pattern_q[7];
`endif
                        end else begin
                            bit_idx_d = next_idx;
                            led_d     = pattern_q[next_idx];
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // stb_prev resets high so a strobe held through reset is not taken as an edge.
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            state_q    <= IDLE;
            stb_prev_q <= 1'b1;
            pattern_q  <= '0;
            bit_idx_q  <= 3'd7;
            presc_q    <= '0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            led_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            stb_prev_q <= stb_prev_d;
            pattern_q  <= pattern_d;
            bit_idx_q  <= bit_idx_d;
            presc_q    <= presc_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            led_q      <= led_d;
        end
    end

    assign ACK_O  = ack_q;
    assign o_busy = busy_q;
    assign o_led  = led_q;

endmodule

// File: tb/tb_prewish5k_pattern_blinker.sv
// Bench for prewish5k_pattern_blinker at PRESCALE_BITS=2; honours PREWISH5K_ONESHOT_EN in its model.
module tb_prewish5k_pattern_blinker;

    localparam int HOLD = 4;

    logic       CLK_I = 1'b0;
    logic       RST_I = 1'b0;
    logic       STB_I = 1'b0;
    logic [7:0] DAT_I = '0;
    logic       ACK_O;
    logic       o_busy;
    logic       o_led;

    int checks = 0;
    int errors = 0;

    // Model: remembers the accepted word and the number of edges since it was accepted.
    logic       m_prev   = 1'b1;
    logic       m_active = 1'b0;
    logic       m_ack    = 1'b0;
    logic [7:0] m_pat    = '0;
    int         m_t      = 0;

    prewish5k_pattern_blinker #(.PRESCALE_BITS(2)) dut (
        .CLK_I (CLK_I),
        .RST_I (RST_I),
        .STB_I (STB_I),
        .DAT_I (DAT_I),
        .ACK_O (ACK_O),
        .o_busy(o_busy),
        .o_led (o_led)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        logic acc;
        if (!RST_I) begin
            m_prev   = 1'b1;
            m_active = 1'b0;
            m_ack    = 1'b0;
            m_pat    = '0;
            m_t      = 0;
        end else begin
            acc    = STB_I && !m_prev;
            m_prev = STB_I;
            m_ack  = acc;
            if (acc) begin
                m_pat    = DAT_I;
                m_t      = 0;
                m_active = 1'b1;
            end else if (m_active) begin
                m_t++;
`ifdef PREWISH5K_ONESHOT_EN
                if (m_t >= 8 * HOLD) m_active = 1'b0;
`endif
            end
        end
    endtask

    function automatic logic model_led();
        int idx;
        if (!m_active) return 1'b0;
        idx = 7 - ((m_t / HOLD) % 8);
        return m_pat[idx];
    endfunction

    task automatic tick();
        @(posedge CLK_I);
        model_step();
        #1;
        check("ack", {31'b0, ACK_O}, {31'b0, m_ack});
        check("busy", {31'b0, o_busy}, {31'b0, m_active});
        check("led", {31'b0, o_led}, {31'b0, model_led()});
    endtask

    initial begin
        int acks;
        int wait_n;
        logic exp_led;

        // Reset with strobe held high; releasing reset must not count as an edge.
        RST_I = 1'b0; STB_I = 1'b1; DAT_I = 8'hFF;
        repeat (3) begin
            tick();
            check("rst_led", {31'b0, o_led}, 32'd0);
            check("rst_ack", {31'b0, ACK_O}, 32'd0);
        end
        RST_I = 1'b1;
        repeat (4) begin
            tick();
            check("rst_noacc", {31'b0, ACK_O | o_busy}, 32'd0);
        end
        STB_I = 1'b0;
        tick();

        // Basic playback: 2-cycle strobe of A5 yields one ack and the MSB-first sequence.
        STB_I = 1'b1; DAT_I = 8'hA5;
        acks = 0;
        for (int c = 0; c < 32; c++) begin
            if (c == 2) STB_I = 1'b0;
            tick();
            if (ACK_O) acks++;
            exp_led = (c / 4 == 0) || (c / 4 == 2) || (c / 4 == 5) || (c / 4 == 7);
            check("a5_led", {31'b0, o_led}, {31'b0, exp_led});
        end
        check("a5_ackcount", acks, 32'd1);

        // 81 over 80 cycles: looping vs one-shot.
        tick();
        for (int c = 0; c < 80; c++) begin
            STB_I = (c == 0);
            DAT_I = 8'h81;
            tick();
`ifdef PREWISH5K_ONESHOT_EN
            exp_led = (c <= 3) || (c >= 28 && c <= 31);
            check("s3_busy", {31'b0, o_busy}, {31'b0, (c < 32)});
`else
            exp_led = (c <= 3) || (c >= 28 && c <= 35) || (c >= 60 && c <= 67);
            check("s3_busy", {31'b0, o_busy}, 32'd1);
`endif
            check("s3_led", {31'b0, o_led}, {31'b0, exp_led});
        end
        STB_I = 1'b0;
        tick();

        // Restart mid-pattern: F0 then 0F six cycles later.
        for (int c = 0; c < 38; c++) begin
            STB_I = (c == 0) || (c == 6);
            DAT_I = (c == 0) ? 8'hF0 : 8'h0F;
            tick();
            if (c == 6) check("s4_ack", {31'b0, ACK_O}, 32'd1);
            if (c >= 6) check("s4_led", {31'b0, o_led}, {31'b0, (c >= 22)});
        end
        STB_I = 1'b0;
        tick();

        // Boundary collision: new strobe exactly on the first prescaler wrap edge.
        for (int c = 0; c < 9; c++) begin
            STB_I = (c == 0) || (c == 4);
            DAT_I = (c == 0) ? 8'h00 : 8'h80;
            tick();
            if (c >= 4 && c <= 7) check("s5_led", {31'b0, o_led}, 32'd1);
            if (c == 8) check("s5_next", {31'b0, o_led}, 32'd0);
        end
        STB_I = 1'b0;
        tick();

        // Reset during bit 3 of FF.
        STB_I = 1'b1; DAT_I = 8'hFF;
        tick();
        STB_I = 1'b0;
        repeat (17) tick();
        RST_I = 1'b0;
        tick();
        check("s6_idle", {30'b0, o_busy, o_led}, 32'd0);
        RST_I = 1'b1;
        repeat (3) tick();

        // Randomized strobes, gaps, data and occasional resets against the model.
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                RST_I = 1'b0;
                STB_I = $urandom_range(0, 1);
                repeat ($urandom_range(1, 2)) tick();
                RST_I = 1'b1;
            end
            DAT_I = 8'($urandom);
            STB_I = 1'b1;
            repeat ($urandom_range(1, 3)) begin
                tick();
                DAT_I = 8'($urandom);
            end
            STB_I = 1'b0;
            wait_n = $urandom_range(1, 40);
            repeat (wait_n) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
